// File: rtl/axi_burst_master_engine.sv
// rtl/axi_burst_master_engine.sv - AXI4 burst master: command + data streams to AXI bursts.
// Optional watchdog built only when AXI_MASTER_TIMEOUT_EN is defined.
module axi_burst_master_engine #(
  parameter int ASIZE           = 32,
  parameter int DSIZE           = 64,
  parameter int LSIZE           = 8,
  parameter int IDSIZE          = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 65535
) (
  input  logic                axi_aclk,
  input  logic                axi_resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ASIZE-1:0]    cmd_addr,
  input  logic [LSIZE-1:0]    cmd_len,
  input  logic [1:0]          cmd_burst,
  input  logic [IDSIZE-1:0]   cmd_id,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DSIZE-1:0]    wr_data,
  input  logic [DSIZE/8-1:0]  wr_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DSIZE-1:0]    rd_data,
  output logic [IDSIZE-1:0]   rd_id,
  output logic [1:0]          rd_resp,
  output logic                rd_last,
  output logic                sts_valid,
  output logic [IDSIZE-1:0]   sts_id,
  output logic [1:0]          sts_resp,
  output logic                sts_write,
  output logic                timeout_err,
  output logic [IDSIZE-1:0]   axi_awid,
  output logic [ASIZE-1:0]    axi_awaddr,
  output logic [LSIZE-1:0]    axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DSIZE-1:0]    axi_wdata,
  output logic [DSIZE/8-1:0]  axi_wstrb,
  output logic                axi_wlast,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [IDSIZE-1:0]   axi_bid,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic [IDSIZE-1:0]   axi_arid,
  output logic [ASIZE-1:0]    axi_araddr,
  output logic [LSIZE-1:0]    axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [IDSIZE-1:0]   axi_rid,
  input  logic [DSIZE-1:0]    axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  input  logic                axi_rvalid,
  output logic                axi_rready
);

  localparam int BYTES = DSIZE / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic              active;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt, wf_cnt;
  logic [PTR_W-1:0]  wf_wp, wf_rp;
  logic [LSIZE-1:0]  wlen_mem [MAX_OUTSTANDING];
  logic [LSIZE-1:0]  beat;
  logic              rej_pending, sts_rej, rej_write;
  logic [IDSIZE-1:0] rej_id;

  logic [31:0] incr_end;
  logic        wrap_ok, cmd_bad;
  logic        cmd_hs, wr_acc, rd_acc, rej_now;
  logic        wf_empty, w_hs, wlast_hs, b_hs, r_hs, rlast_hs;

  // Burst end offset within the 4KB page; equal to 4096 is still legal.
  assign incr_end = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES);
  assign wrap_ok  = (cmd_len == LSIZE'(1)) || (cmd_len == LSIZE'(3)) ||
                    (cmd_len == LSIZE'(7)) || (cmd_len == LSIZE'(15));
  assign cmd_bad  = (cmd_burst == 2'b11) ||
                    ((cmd_burst == 2'b10) && !wrap_ok) ||
                    ((cmd_burst == 2'b01) && (incr_end > 32'd4096));

  assign cmd_ready = active && !rej_pending && !sts_rej &&
                     (cmd_write ? ((wr_cnt != CNT_MAX) && !axi_awvalid)
                                : ((rd_cnt != CNT_MAX) && !axi_arvalid));
  assign cmd_hs  = cmd_valid && cmd_ready;
  assign wr_acc  = cmd_hs && cmd_write && !cmd_bad;
  assign rd_acc  = cmd_hs && !cmd_write && !cmd_bad;
  assign rej_now = cmd_hs && cmd_bad;

  assign wf_empty   = (wf_cnt == '0);
  assign axi_wvalid = wr_valid && !wf_empty;
  assign wr_ready   = axi_wready && !wf_empty;
  assign axi_wdata  = wr_data;
  assign axi_wstrb  = wr_strb;
  assign axi_wlast  = !wf_empty && (beat == wlen_mem[wf_rp]);
  assign w_hs       = axi_wvalid && axi_wready;
  assign wlast_hs   = w_hs && axi_wlast;

  assign axi_bready = active;
  assign b_hs       = axi_bvalid && axi_bready;

  assign axi_rready = rd_ready;
  assign rd_valid   = axi_rvalid;
  assign rd_data    = axi_rdata;
  assign rd_id      = axi_rid;
  assign rd_resp    = axi_rresp;
  assign rd_last    = axi_rlast;
  assign r_hs       = axi_rvalid && axi_rready;
  assign rlast_hs   = r_hs && axi_rlast;

  assign axi_awsize = 3'($clog2(BYTES));
  assign axi_arsize = 3'($clog2(BYTES));

  always_ff @(posedge axi_aclk) begin
    if (wr_acc) wlen_mem[wf_wp] <= cmd_len;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      active      <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_awid    <= '0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awburst <= '0;
      axi_arvalid <= 1'b0;
      axi_arid    <= '0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arburst <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wf_cnt      <= '0;
      wf_wp       <= '0;
      wf_rp       <= '0;
      beat        <= '0;
    end else begin
      active <= 1'b1;
      if (wr_acc) begin
        axi_awvalid <= 1'b1;
        axi_awid    <= cmd_id;
        axi_awaddr  <= cmd_addr;
        axi_awlen   <= cmd_len;
        axi_awburst <= cmd_burst;
      end else if (axi_awready) begin
        axi_awvalid <= 1'b0;
      end
      if (rd_acc) begin
        axi_arvalid <= 1'b1;
        axi_arid    <= cmd_id;
        axi_araddr  <= cmd_addr;
        axi_arlen   <= cmd_len;
        axi_arburst <= cmd_burst;
      end else if (axi_arready) begin
        axi_arvalid <= 1'b0;
      end
      if (wr_acc && !b_hs) wr_cnt <= wr_cnt + CNT_W'(1);
      else if (!wr_acc && b_hs) wr_cnt <= wr_cnt - CNT_W'(1);
      if (rd_acc && !rlast_hs) rd_cnt <= rd_cnt + CNT_W'(1);
      else if (!rd_acc && rlast_hs) rd_cnt <= rd_cnt - CNT_W'(1);
      if (wr_acc) wf_wp <= (wf_wp == PTR_LAST) ? '0 : wf_wp + PTR_W'(1);
      if (wlast_hs) wf_rp <= (wf_rp == PTR_LAST) ? '0 : wf_rp + PTR_W'(1);
      if (wr_acc && !wlast_hs) wf_cnt <= wf_cnt + CNT_W'(1);
      else if (!wr_acc && wlast_hs) wf_cnt <= wf_cnt - CNT_W'(1);
      if (wlast_hs) beat <= '0;
      else if (w_hs) beat <= beat + LSIZE'(1);
    end
  end

  // B status wins the slot; a colliding reject waits in rej_pending.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      sts_valid   <= 1'b0;
      sts_id      <= '0;
      sts_resp    <= '0;
      sts_write   <= 1'b0;
      sts_rej     <= 1'b0;
      rej_pending <= 1'b0;
      rej_id      <= '0;
      rej_write   <= 1'b0;
    end else begin
      sts_valid   <= b_hs || rej_now || rej_pending;
      sts_rej     <= !b_hs && (rej_now || rej_pending);
      rej_pending <= b_hs && (rej_now || rej_pending);
      if (b_hs) begin
        sts_id    <= axi_bid;
        sts_resp  <= axi_bresp;
        sts_write <= 1'b1;
      end else if (rej_now) begin
        sts_id    <= cmd_id;
        sts_resp  <= 2'b10;
        sts_write <= cmd_write;
      end else if (rej_pending) begin
        sts_id    <= rej_id;
        sts_resp  <= 2'b10;
        sts_write <= rej_write;
      end
      if (rej_now) begin
        rej_id    <= cmd_id;
        rej_write <= cmd_write;
      end
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (b_hs || r_hs) wd_cnt <= '0;
      else if (((wr_cnt != '0) || (rd_cnt != '0)) && (wd_cnt != 16'(TIMEOUT)))
        wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt == 16'(TIMEOUT)) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/axi_burst_master_engine.md
Name: axi_burst_master_engine

Overview:
- Synthesisable, parametrised AXI4 master engine; turns a simple command stream plus write/read data streams into AXI bursts.
- Sits between a DMA or test-traffic generator and an AXI interconnect port.
- Supports multiple outstanding writes and reads, independent write/read paths, INCR/FIXED/WRAP bursts, and legality checks on every command.

Parameters:
- ASIZE, 32, address width
- DSIZE, 64, data width (power of 2, 32..1024)
- LSIZE, 8, AXI len field width; max burst = 2^LSIZE beats
- IDSIZE, 4, AXI ID width
- MAX_OUTSTANDING, 4, max in-flight transactions per direction (power of 2, 1..16)
- TIMEOUT, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
- axi_aclk  in  1  single clock, all logic on rising edge
- axi_resetn  in  1  reset, synchronous, active-low
- cmd_valid/cmd_ready  in/out  1/1  command handshake
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ASIZE  start byte address, DSIZE/8 aligned
- cmd_len  in  LSIZE  beats-1
- cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- cmd_id  in  IDSIZE  transaction ID
- wr_valid/wr_ready  in/out  1/1  write-data stream handshake
- wr_data/wr_strb  in  DSIZE/DSIZE/8  write beat payload
- rd_valid/rd_ready  out/in  1/1  read-data stream handshake
- rd_data/rd_id/rd_resp/rd_last  out  DSIZE/IDSIZE/2/1  read beat payload
- sts_valid  out  1  one-cycle status pulse
- sts_id/sts_resp/sts_write  out  IDSIZE/2/1  status payload
- timeout_err  out  1  sticky watchdog flag
- axi_aw{id,addr,len,size,burst,valid}/axi_awready  out/in  AW channel
- axi_w{data,strb,last,valid}/axi_wready  out/in  W channel
- axi_b{id,resp,valid}/axi_bready  in/out  B channel
- axi_ar{id,addr,len,size,burst,valid}/axi_arready  out/in  AR channel
- axi_r{id,data,resp,last,valid}/axi_rready  in/out  R channel

Behaviour:
- Reset (axi_resetn=0 at an edge): all valids, sts_valid, timeout_err, counters and FIFOs cleared. cmd_ready=1 and axi_bready=1 from the first edge after release. AW/AR payload registers go to 0.
- awsize/arsize constant = log2(DSIZE/8). awlock, awcache, awprot, awqos and the AR equivalents are not driven by this block.
- Command check, combinational on the cmd fields. A command is rejected if:
  - WRAP with cmd_len not in {1,3,7,15};
  - INCR where (cmd_addr[11:0] + (cmd_len+1)*DSIZE/8) > 4096;
  - cmd_burst==11.
- Rejected command: accepted by handshake, generates no AXI traffic. Status pending register is set; sts_valid pulses with sts_resp=10 and sts_id=cmd_id on the next cycle without a B handshake. cmd_ready stays 0 while the reject status is pending.
- cmd_ready=0 when any of the following holds:
  - the target-direction outstanding count == MAX_OUTSTANDING;
  - the AW/AR register for that direction is still valid;
  - a reject status is pending.
- AW/AR: registered; valid asserts the cycle after command acceptance and holds, with stable payload, until the ready handshake.
- Write length FIFO: depth MAX_OUTSTANDING, pushed on command acceptance, popped on the wlast handshake.
  - W valid = wr_valid AND FIFO non-empty; wr_ready = axi_wready AND FIFO non-empty. Pass-through, zero latency.
  - Beat counter generates wlast on beat len+1. W beats may precede the AW handshake.
- Write outstanding count: +1 on acceptance, -1 on B handshake; simultaneous events leave it unchanged. Each B handshake yields sts_valid with sts_write=1, sts_id=bid, sts_resp=bresp. B status has priority over a pending reject.
- Read path: pass-through; rready = rd_ready and the rd_* fields mirror the R channel. Read outstanding count: -1 on the rlast handshake.
- No reordering is done. IDs are passed through unchanged.
- Reset mid-operation: in-flight bursts are abandoned with no completion or status. The slave is expected to reset together with this block.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- When defined: a 16-bit watchdog counts cycles while either outstanding count > 0 and no B/R handshake occurs. Any B/R handshake clears it. On reaching TIMEOUT, timeout_err is set and remains set until reset.
- When undefined: no counter is built and timeout_err is tied to 0.

Test Plan:
- Write INCR, addr 0x1000, len 3, id 2, data 1..4, slave always ready -> axi_awaddr=0x1000, awlen=3, awburst=01, awsize=3; 4 W beats with wlast on the 4th; bresp 00 -> sts_valid with id 2, resp 00, write=1.
- Read WRAP, addr 0x2010, len 7; rd_ready held low 3 cycles mid-burst -> arlen=7, arburst=10; rready low during the stall; 8 beats delivered in order; rd_last on beat 8.
- 5 writes issued back-to-back with bvalid withheld -> 4 AW handshakes; cmd_ready=0 on the 5th until the first B handshake, then the 5th AW issues.
- WRAP with len 5 -> no AW; sts_resp=10. INCR at 0xFF0 with len 3 (64-bit data, crosses 4KB) -> rejected the same way. B response and pending reject in the same cycle -> B status first, reject status next cycle.
- Reset asserted after 2 of 8 W beats -> all AXI valids and sts_valid at 0 after the edge; outstanding counts 0; cmd_ready=1 after release.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT=100: read issued, rvalid never asserted -> timeout_err=1 exactly 100 cycles after the AR handshake, held until reset.
